// File: rtl/pwm_capture.sv
// PWM burst measurement: period/high time per pulse, pulse count per burst,
// burst end detected by an idle timeout on the synchronised line.
module pwm_capture #(
    parameter int CNT_W       = 32,
    parameter int TIMES_W     = 16,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_pwm,
    output logic [CNT_W-1:0]   o_period,
    output logic [CNT_W-1:0]   o_high,
    output logic               o_meas_vld,
    output logic [TIMES_W-1:0] o_times,
    output logic               o_done,
    output logic               o_busy,
    output logic               o_ovf
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        MEAS
    } state_t;

    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
    localparam logic [TIMES_W-1:0] PUL_MAX  = '1;
    localparam logic [CNT_W-1:0]   IDLE_END = CNT_W'(TIMEOUT_CYC - 1);

    logic s1;
    logic s2;
    logic s3;
    logic rise;
    logic fall;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   high_tmp;
    logic [CNT_W-1:0]   idle;
    logic [TIMES_W-1:0] pulses;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= i_pwm;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            high_tmp   <= '0;
            idle       <= '0;
            pulses     <= '0;
            o_period   <= '0;
            o_high     <= '0;
            o_meas_vld <= 1'b0;
            o_times    <= '0;
            o_done     <= 1'b0;
            o_busy     <= 1'b0;
            o_ovf      <= 1'b0;
        end else begin
            o_meas_vld <= 1'b0;
            o_done     <= 1'b0;
            if (!i_en) begin
                state  <= IDLE;
                o_busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ARMED;
                        o_ovf <= 1'b0;
                    end
                    ARMED: begin
                        if (rise) begin
                            state  <= MEAS;
                            cnt    <= CNT_W'(1);
                            pulses <= TIMES_W'(1);
                            idle   <= '0;
                            o_busy <= 1'b1;
                        end
                    end
                    MEAS: begin
                        if (cnt == CNT_MAX) o_ovf <= 1'b1;
                        else                cnt   <= cnt + 1'b1;
                        if (rise) begin
                            o_period   <= cnt;
                            o_high     <= high_tmp;
                            o_meas_vld <= 1'b1;
                            cnt        <= CNT_W'(1);
                            if (pulses == PUL_MAX) o_ovf  <= 1'b1;
                            else                   pulses <= pulses + 1'b1;
                        end
                        if (fall) high_tmp <= cnt;
                        // an edge coinciding with the timeout keeps the burst alive
                        if (rise | fall) begin
                            idle <= '0;
                        end else if (idle == IDLE_END) begin
                            o_times <= pulses;
                            o_done  <= 1'b1;
                            o_busy  <= 1'b0;
                            state   <= ARMED;
                        end else begin
                            idle <= idle + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: two instances (wide and 8-bit counters) driven by
// the same line, checked every cycle against a timestamp-based model.
module tb_pwm_capture;

    localparam int TMO_A = 64;
    localparam int TMO_B = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic en    = 1'b0;
    logic pwm   = 1'b0;

    logic [31:0] a_period;
    logic [31:0] a_high;
    logic        a_vld;
    logic [15:0] a_times;
    logic        a_done;
    logic        a_busy;
    logic        a_ovf;
    logic [7:0]  b_period;
    logic [7:0]  b_high;
    logic        b_vld;
    logic [15:0] b_times;
    logic        b_done;
    logic        b_busy;
    logic        b_ovf;

    pwm_capture #(.CNT_W(32), .TIMES_W(16), .TIMEOUT_CYC(TMO_A)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_pwm(pwm),
        .o_period(a_period), .o_high(a_high), .o_meas_vld(a_vld),
        .o_times(a_times), .o_done(a_done), .o_busy(a_busy), .o_ovf(a_ovf)
    );

    pwm_capture #(.CNT_W(8), .TIMES_W(16), .TIMEOUT_CYC(TMO_B)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_pwm(pwm),
        .o_period(b_period), .o_high(b_high), .o_meas_vld(b_vld),
        .o_times(b_times), .o_done(b_done), .o_busy(b_busy), .o_ovf(b_ovf)
    );

    int total = 0;
    int bad   = 0;
    int vld_a = 0;
    int done_a = 0;
    bit arm = 1'b0;

    // model: 0 off, 1 armed, 2 in burst; times are edge indices
    longint n = 0;
    bit     smp [3];
    int     mode [2];
    longint t_rise [2];
    longint t_fall [2];
    longint t_edge [2];
    longint pulses [2];
    longint e_period [2];
    longint e_high [2];
    longint e_times [2];
    bit     e_vld [2];
    bit     e_done [2];
    bit     e_busy [2];
    bit     e_ovf [2];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic mdl(input int i, input longint cmax, input longint pmax,
                       input longint tmo, input bit rs, input bit fl);
        e_vld[i]  = 1'b0;
        e_done[i] = 1'b0;
        if (!rst_n) begin
            mode[i] = 0;
            t_rise[i] = 0; t_fall[i] = 0; t_edge[i] = 0; pulses[i] = 0;
            e_period[i] = 0; e_high[i] = 0; e_times[i] = 0;
            e_busy[i] = 1'b0; e_ovf[i] = 1'b0;
        end else if (!en) begin
            mode[i]   = 0;
            e_busy[i] = 1'b0;
        end else if (mode[i] == 0) begin
            mode[i]  = 1;
            e_ovf[i] = 1'b0;
        end else if (mode[i] == 1) begin
            if (rs) begin
                mode[i] = 2;
                t_rise[i] = n; t_edge[i] = n; pulses[i] = 1;
                e_busy[i] = 1'b1;
            end
        end else begin
            if (n - t_rise[i] >= cmax) e_ovf[i] = 1'b1;
            if (rs) begin
                e_period[i] = (n - t_rise[i] > cmax) ? cmax : n - t_rise[i];
                e_high[i] = (t_fall[i] - t_rise[i] > cmax) ? cmax
                                                           : t_fall[i] - t_rise[i];
                e_vld[i] = 1'b1;
                if (pulses[i] >= pmax) e_ovf[i] = 1'b1;
                else pulses[i]++;
                t_rise[i] = n;
            end
            if (fl) t_fall[i] = n;
            if (rs || fl) begin
                t_edge[i] = n;
            end else if (n - t_edge[i] == tmo) begin
                e_done[i] = 1'b1;
                e_times[i] = pulses[i];
                e_busy[i] = 1'b0;
                mode[i] = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("a.period", 64'(a_period), e_period[0]);
        chk("a.high",   64'(a_high),   e_high[0]);
        chk("a.vld",    64'(a_vld),    64'(e_vld[0]));
        chk("a.times",  64'(a_times),  e_times[0]);
        chk("a.done",   64'(a_done),   64'(e_done[0]));
        chk("a.busy",   64'(a_busy),   64'(e_busy[0]));
        chk("a.ovf",    64'(a_ovf),    64'(e_ovf[0]));
        chk("b.period", 64'(b_period), e_period[1]);
        chk("b.high",   64'(b_high),   e_high[1]);
        chk("b.vld",    64'(b_vld),    64'(e_vld[1]));
        chk("b.times",  64'(b_times),  e_times[1]);
        chk("b.done",   64'(b_done),   64'(e_done[1]));
        chk("b.busy",   64'(b_busy),   64'(e_busy[1]));
        chk("b.ovf",    64'(b_ovf),    64'(e_ovf[1]));
        if (a_vld === 1'b1) vld_a++;
        if (a_done === 1'b1) done_a++;
    endtask

    task automatic step(input bit r, input bit e, input bit p);
        bit rs;
        bit fl;
        @(negedge clk);
        rst_n = r;
        en    = e;
        pwm   = p;
        @(posedge clk);
        n++;
        rs = smp[1] & ~smp[2];
        fl = ~smp[1] & smp[2];
        if (!rst_n) begin
            smp = '{default: 1'b0};
        end else begin
            smp[2] = smp[1];
            smp[1] = smp[0];
            smp[0] = pwm;
        end
        mdl(0, 64'hFFFF_FFFF, 65535, TMO_A, rs, fl);
        mdl(1, 255, 65535, TMO_B, rs, fl);
        #1 check_all();
    endtask

    task automatic run(input int k, input bit p);
        for (int i = 0; i < k; i++) step(1'b1, arm, p);
    endtask

    task automatic pulse(input int h, input int l);
        run(h, 1'b1);
        run(l, 1'b0);
    endtask

    initial begin
        smp = '{default: 1'b0};
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        chk("rst.period", 64'(a_period), 0);
        chk("rst.busy",   64'(a_busy),   0);

        // five pulses of period 10 / high 4
        arm = 1'b1;
        vld_a = 0; done_a = 0;
        run(3, 1'b0);
        for (int i = 0; i < 5; i++) pulse(4, 6);
        run(80, 1'b0);
        chk("s1.vld_cnt",  vld_a, 4);
        chk("s1.done_cnt", done_a, 1);
        chk("s1.period", 64'(a_period), 10);
        chk("s1.high",   64'(a_high), 4);
        chk("s1.times",  64'(a_times), 5);
        chk("s1.ovf",    64'(a_ovf), 0);

        // disarm after the third rise
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        vld_a = 0; done_a = 0;
        run(3, 1'b0);
        pulse(4, 6);
        pulse(4, 6);
        run(4, 1'b1);
        arm = 1'b0;
        run(6, 1'b0);
        pulse(4, 6);
        pulse(4, 6);
        run(80, 1'b0);
        chk("s2.vld_cnt",  vld_a, 2);
        chk("s2.done_cnt", done_a, 0);
        chk("s2.times",  64'(a_times), 0);
        chk("s2.period", 64'(a_period), 10);
        chk("s2.high",   64'(a_high), 4);

        // line already high when armed
        vld_a = 0; done_a = 0;
        run(5, 1'b1);
        arm = 1'b1;
        run(3, 1'b1);
        run(3, 1'b0);
        run(2, 1'b1);
        run(3, 1'b0);
        run(2, 1'b1);
        run(80, 1'b0);
        chk("s3.vld_cnt", vld_a, 1);
        chk("s3.period", 64'(a_period), 5);
        chk("s3.high",   64'(a_high), 2);
        chk("s3.times",  64'(a_times), 2);

        // burst ends during a long high phase
        vld_a = 0; done_a = 0;
        run(999, 1'b1);
        run(1, 1'b0);
        run(999, 1'b1);
        run(80, 1'b0);
        chk("s4.vld_cnt",  vld_a, 0);
        chk("s4.done_cnt", done_a, 2);
        chk("s4.times", 64'(a_times), 1);

        // rise on the exact timeout cycle
        vld_a = 0; done_a = 0;
        pulse(3, 64);
        pulse(3, 80);
        chk("s5.vld_cnt",  vld_a, 1);
        chk("s5.done_cnt", done_a, 1);
        chk("s5.period", 64'(a_period), 67);
        chk("s5.high",   64'(a_high), 3);
        chk("s5.times",  64'(a_times), 2);

        // 8-bit counter saturation, cleared by re-arm
        arm = 1'b0;
        run(1, 1'b0);
        arm = 1'b1;
        run(2, 1'b0);
        for (int i = 0; i < 3; i++) pulse(200, 100);
        run(300, 1'b0);
        chk("s6.b_ovf",    64'(b_ovf), 1);
        chk("s6.b_period", 64'(b_period), 255);
        chk("s6.b_high",   64'(b_high), 200);
        chk("s6.b_times",  64'(b_times), 3);
        arm = 1'b0;
        run(1, 1'b0);
        arm = 1'b1;
        run(2, 1'b0);
        chk("s6.b_ovf_clr", 64'(b_ovf), 0);

        // reset in the middle of a burst
        pulse(3, 3);
        run(3, 1'b1);
        step(1'b0, arm, 1'b1);
        chk("s7.a_period", 64'(a_period), 0);
        chk("s7.a_high",   64'(a_high), 0);
        chk("s7.a_times",  64'(a_times), 0);
        chk("s7.a_busy",   64'(a_busy), 0);
        chk("s7.b_busy",   64'(b_busy), 0);
        run(5, 1'b0);

        // random bursts, occasional disarm
        for (int b = 0; b < 10; b++) begin
            int np;
            np = int'($urandom_range(1, 6));
            for (int p = 0; p < np; p++) begin
                pulse(int'($urandom_range(1, 12)), int'($urandom_range(1, 70)));
                if ($urandom_range(0, 7) == 0) begin
                    arm = 1'b0;
                    run(int'($urandom_range(1, 3)), 1'b0);
                    arm = 1'b1;
                end
            end
            run(int'($urandom_range(0, 320)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
